ysyx_220066_div: RTL

- Iterative radix-2 restoring divider feeding the Div_* inputs of the write-back stage.
- Executes RV64M DIV/DIVU/REM/REMU and the W variants. Carries rd, next-PC and the error flag alongside the operands.
- Holds its result until write-back has retired it, using write-back's div_block backpressure.
- Exposes busy and busy_rd to the issue logic for hazard checks.

---
 rtl/ysyx_220066_div.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_220066_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow skip CALC.
module ysyx_220066_div #(
    parameter int STEPS = 1,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op_rem,
    input  logic            op_unsigned,
    input  logic            op_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] nxtpc_in,
    input  logic            error_in,
    input  logic            flush,
    input  logic            div_block,
    output logic            div_wen_out,
    output logic [4:0]      div_rd_out,
    output logic [XLEN-1:0] div_data_out,
    output logic [XLEN-1:0] div_nxtpc_out,
    output logic            div_error_out,
    output logic            busy,
    output logic [4:0]      busy_rd
);
    // state | meaning
    // IDLE  | ready for a request
    // CALC  | STEPS shift/trial-subtract steps per cycle
    // FIX   | sign correction, result select, output register load
    // DONE  | result presented to write-back (div_wen_out=1)
    // ACK   | wait for write-back retire, re-present on div_block
    typedef enum logic [2:0] {IDLE, CALC, FIX, DONE, ACK} state_e;

    state_e            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic              op_rem_q, op_rem_d, op_word_q, op_word_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   nxtpc_q, nxtpc_d;
    logic              err_q, err_d;
    logic              wen_q, wen_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic [XLEN-1:0]   out_data_q, out_data_d, out_nxtpc_q, out_nxtpc_d;
    logic              out_err_q, out_err_d;

    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
    logic              s1, s2, div_zero;
    logic [XLEN-1:0]   step_rem, step_quo;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   q_fix, r_fix, res;
`ifdef DIV_FASTPATH_EN
    logic              ovf;
`endif

    always_comb begin
        a_ext = op_word ? (op_unsigned ? {32'b0, src1[31:0]} : {{32{src1[31]}}, src1[31:0]}) : src1;
        b_ext = op_word ? (op_unsigned ? {32'b0, src2[31:0]} : {{32{src2[31]}}, src2[31:0]}) : src2;
        s1       = !op_unsigned && a_ext[XLEN-1];
        s2       = !op_unsigned && b_ext[XLEN-1];
        a_mag    = s1 ? -a_ext : a_ext;
        b_mag    = s2 ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
`ifdef DIV_FASTPATH_EN
        ovf = !op_unsigned && (&b_ext) &&
              (a_ext == (op_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
`endif
    end

    // STEPS restoring steps chained combinationally on {remainder, quotient}
    always_comb begin
        step_rem = rem_q;
        step_quo = quo_q;
        trial    = '0;
        for (int i = 0; i < STEPS; i++) begin
            trial    = {step_rem, step_quo[XLEN-1]};
            step_quo = {step_quo[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                trial       = trial - {1'b0, dvs_q};
                step_quo[0] = 1'b1;
            end
            step_rem = trial[XLEN-1:0];
        end
    end

    always_comb begin
        q_fix = op_word_q ? {32'b0, quo_q[31:0]} : quo_q;
        r_fix = rem_q;
        if (qneg_q) q_fix = -q_fix;
        if (rneg_q) r_fix = -r_fix;
        res = op_rem_q ? r_fix : q_fix;
        if (op_word_q) res = {{32{res[31]}}, res[31:0]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        op_rem_d    = op_rem_q;
        op_word_d   = op_word_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        rd_d        = rd_q;
        nxtpc_d     = nxtpc_q;
        err_d       = err_q;
        wen_d       = 1'b0;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        out_nxtpc_d = out_nxtpc_q;
        out_err_d   = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rd_d      = rd_in;
                    nxtpc_d   = nxtpc_in;
                    err_d     = error_in;
                    op_rem_d  = op_rem;
                    op_word_d = op_word;
                    // quotient of x/0 stays all ones, so its sign is never applied
                    qneg_d    = (s1 ^ s2) && !div_zero;
                    rneg_d    = s1;
                    rem_d     = '0;
                    quo_d     = op_word ? {a_mag[31:0], 32'b0} : a_mag;
                    dvs_d     = b_mag;
                    cnt_d     = op_word ? 7'(32 / STEPS) : 7'(64 / STEPS);
                    state_d   = CALC;
`ifdef DIV_FASTPATH_EN
                    if (div_zero) begin
                        rem_d   = a_mag;
                        quo_d   = '1;
                        state_d = FIX;
                    end else if (ovf) begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) state_d = FIX;
                end
            end
            FIX: begin
                out_data_d  = res;
                out_rd_d    = rd_q;
                out_nxtpc_d = nxtpc_q;
                out_err_d   = err_q;
                wen_d       = 1'b1;
                state_d     = DONE;
            end
            DONE: state_d = ACK;
            ACK: begin
                if (div_block) begin
                    wen_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            op_rem_q    <= 1'b0;
            op_word_q   <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            rd_q        <= '0;
            nxtpc_q     <= '0;
            err_q       <= 1'b0;
            wen_q       <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            out_nxtpc_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            op_rem_q    <= op_rem_d;
            op_word_q   <= op_word_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            rd_q        <= rd_d;
            nxtpc_q     <= nxtpc_d;
            err_q       <= err_d;
            wen_q       <= wen_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            out_nxtpc_q <= out_nxtpc_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready      = (state_q == IDLE) && !rst;
    assign busy          = (state_q != IDLE);
    assign busy_rd       = rd_q;
    assign div_wen_out   = wen_q;
    assign div_rd_out    = out_rd_q;
    assign div_data_out  = out_data_q;
    assign div_nxtpc_out = out_nxtpc_q;
    assign div_error_out = out_err_q;
endmodule
